// File: rtl/hex_display_ctrl.sv
// Multi-digit active-low seven-segment controller: latches a value and shows it in hex or decimal,
// with overflow dashes, leading-zero blanking and whole-display blinking.
module hex_display_ctrl #(
  parameter int unsigned NUM_DIGITS = 6,
  parameter int unsigned VALUE_W    = 20,
  parameter int unsigned BLINK_DIV  = 25000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [VALUE_W-1:0]      value,
  input  logic                    load,
  input  logic                    mode,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [7*NUM_DIGITS-1:0] seg,
  output logic                    busy,
  output logic                    done,
  output logic                    overflow
);

  localparam int unsigned BcdW   = 4 * NUM_DIGITS;
  localparam int unsigned CntW   = $clog2(VALUE_W);
  localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SegBlank = 7'b1111111;
  localparam logic [6:0] SegDash  = 7'b0111111;

  typedef enum logic [1:0] {StIdle, StConvert, StUpdate} state_e;

  state_e              state_q;
  logic [VALUE_W-1:0]  shift_q;
  logic                mode_q;
  logic [BcdW-1:0]     bcd_q;
  logic                ovf_acc_q;
  logic [CntW-1:0]     cnt_q;
  logic [BcdW-1:0]     digits_q;
  logic                overflow_q;
  logic                busy_q;
  logic                done_q;
  logic [BlinkW-1:0]   blink_cnt_q;
  logic                blink_off_q;

  logic [BcdW-1:0]     bcd_adj;
  logic [BcdW-1:0]     bcd_shift;
  logic                carry_out;
  logic [BcdW-1:0]     hex_digits;

  function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'b1000000;
      4'h1: g = 7'b1111001;
      4'h2: g = 7'b0100100;
      4'h3: g = 7'b0110000;
      4'h4: g = 7'b0011001;
      4'h5: g = 7'b0010010;
      4'h6: g = 7'b0000010;
      4'h7: g = 7'b1111000;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0010000;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b0000011;
      4'hC: g = 7'b1000110;
      4'hD: g = 7'b0100001;
      4'hE: g = 7'b0000110;
      default: g = 7'b0001110;
    endcase
    return g;
  endfunction

  // Double-dabble step: adjust nibbles >= 5, then shift in the next value bit MSB first.
  always_comb begin
    bcd_adj = '0;
    for (int d = 0; d < int'(NUM_DIGITS); d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      else                         bcd_adj[4*d +: 4] = bcd_q[4*d +: 4];
    end
    bcd_shift = {bcd_adj[BcdW-2:0], shift_q[VALUE_W-1]};
    // A bit leaving the top digit means the value needs more than NUM_DIGITS decimal digits.
    carry_out = bcd_adj[BcdW-1];
  end

  for (genvar b = 0; b < int'(BcdW); b++) begin : g_hex
    if (b < int'(VALUE_W)) begin : g_bit
      assign hex_digits[b] = shift_q[b];
    end else begin : g_pad
      assign hex_digits[b] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      shift_q     <= '0;
      mode_q      <= 1'b0;
      bcd_q       <= '0;
      ovf_acc_q   <= 1'b0;
      cnt_q       <= '0;
      digits_q    <= '0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else begin
      if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BlinkW'(1);
      end

      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // busy_q is still high here only during the done cycle.
          if (busy_q) begin
            busy_q <= 1'b0;
          end else if (load) begin
            shift_q   <= value;
            mode_q    <= mode;
            bcd_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b1;
            state_q   <= mode ? StConvert : StUpdate;
          end
        end
        StConvert: begin
          bcd_q     <= bcd_shift;
          ovf_acc_q <= ovf_acc_q | carry_out;
          shift_q   <= {shift_q[VALUE_W-2:0], 1'b0};
          cnt_q     <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(VALUE_W - 1)) state_q <= StUpdate;
        end
        StUpdate: begin
          digits_q   <= mode_q ? bcd_q : hex_digits;
          overflow_q <= mode_q & ovf_acc_q;
          done_q     <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic       lead_zero;
  logic [3:0] nib_c;

  always_comb begin
    seg       = '0;
    lead_zero = 1'b1;
    nib_c     = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
      nib_c     = digits_q[4*i +: 4];
      lead_zero = lead_zero & (nib_c == 4'd0);
      if (blink_en && blink_off_q)            seg[7*i +: 7] = SegBlank;
      else if (overflow_q)                    seg[7*i +: 7] = SegDash;
      else if (blank_lz && lead_zero && i != 0) seg[7*i +: 7] = SegBlank;
      else                                    seg[7*i +: 7] = hex_glyph(nib_c);
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Directed bench for hex_display_ctrl (4 digits, 16-bit value, blink divider 4) with a
// scoreboard of expected display contents.
module tb_hex_display_ctrl;

  localparam int unsigned Nd = 4;
  localparam int unsigned Vw = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [Vw-1:0] value;
  logic          load;
  logic          mode;
  logic          blank_lz;
  logic          blink_en;
  logic [7*Nd-1:0] seg;
  logic          busy;
  logic          done;
  logic          overflow;

  hex_display_ctrl #(
    .NUM_DIGITS(Nd),
    .VALUE_W   (Vw),
    .BLINK_DIV (4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .value   (value),
    .load    (load),
    .mode    (mode),
    .blank_lz(blank_lz),
    .blink_en(blink_en),
    .seg     (seg),
    .busy    (busy),
    .done    (done),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [27:0] seg;
    logic        ovf;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   e0_cyc   = 0;

  localparam logic [27:0] AllZero  = {4{7'b1000000}};
  localparam logic [27:0] AllBlank = {28{1'b1}};

  logic [6:0] glyphs [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  int pow10 [4] = '{1, 10, 100, 1000};

  function automatic exp_t model(input int unsigned v, input bit m, input bit blz);
    exp_t        e;
    int unsigned d [4];
    int          top;
    e.ovf = m && (v >= 10000);
    e.lat = m ? 17 : 1;
    top   = 0;
    for (int i = 0; i < 4; i++) begin
      d[i] = m ? (v / pow10[i]) % 10 : (v >> (4 * i)) & 15;
      if (d[i] != 0) top = i;
    end
    for (int i = 0; i < 4; i++) begin
      if (e.ovf)                e.seg[7*i +: 7] = 7'b0111111;
      else if (blz && i > top)  e.seg[7*i +: 7] = 7'b1111111;
      else                      e.seg[7*i +: 7] = glyphs[d[i]];
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input int unsigned v, input bit m);
    @(negedge clk);
    value = Vw'(v);
    mode  = m;
    load  = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    e0_cyc = cyc;
    check("busy_after_load", busy, 1);
    sb.push_back(model(v, m, blank_lz));
  endtask

  task automatic wait_done(input string tag);
    bit   seen;
    exp_t e;
    seen = 1'b0;
    for (int j = 0; j < 40; j++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_done_seen"}, seen, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        check({tag, "_seg"}, seg, e.seg);
        check({tag, "_ovf"}, overflow, e.ovf);
        check({tag, "_latency"}, cyc - e0_cyc, e.lat);
        @(negedge clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_busy_low"}, busy, 0);
      end
    end
  endtask

  initial begin
    bit prev_blank;
    bit found;
    bit done_seen;

    reset    = 1'b1;
    value    = '0;
    load     = 1'b0;
    mode     = 1'b0;
    blank_lz = 1'b0;
    blink_en = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("reset_seg", seg, AllZero);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ovf", overflow, 0);

    do_load(16'hBEEF, 1'b0);
    wait_done("hex_beef");

    // Second load during conversion must be dropped.
    do_load(1234, 1'b1);
    @(negedge clk);
    value = 16'd5555;
    mode  = 1'b0;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
    wait_done("dec_1234");
    repeat (3) @(negedge clk);
    check("no_queued_load", busy | done, 0);

    do_load(12345, 1'b1);
    wait_done("dec_ovf");
    do_load(9999, 1'b1);
    wait_done("dec_9999");

    blank_lz = 1'b1;
    do_load(7, 1'b1);
    wait_done("blank_7");
    do_load(0, 1'b1);
    wait_done("blank_0");
    @(negedge clk);
    blank_lz = 1'b0;
    #1;
    check("blank_lz_live", seg, AllZero);

    blink_en   = 1'b1;
    prev_blank = 1'b1;
    found      = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if ((seg == AllBlank) && !prev_blank) begin
        found = 1'b1;
        break;
      end
      prev_blank = (seg == AllBlank);
    end
    check("blink_edge_found", found, 1);
    for (int j = 0; j < 12; j++) begin
      check("blink_phase", seg, ((j < 4) || (j >= 8)) ? AllBlank : AllZero);
      @(negedge clk);
    end
    blink_en = 1'b0;

    do_load(16'h1234, 1'b0);
    wait_done("hex_1234");
    @(negedge clk);
    value = 16'd4321;
    mode  = 1'b1;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_seg", seg, AllZero);
    check("abort_ovf", overflow, 0);
    done_seen = 1'b0;
    for (int j = 0; j < 25; j++) begin
      @(negedge clk);
      if (done) done_seen = 1'b1;
    end
    check("abort_no_done", done_seen, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
